// File: rtl/a2d_pkg.sv
// Shared types and helpers for the round-robin A/D channel sequencer.
package a2d_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SEND1,
        WAIT1,
        GAP,
        SEND2,
        WAIT2,
        NEXT,
        CMPLT
    } seq_state_t;

    localparam int NUM_CH = 3;

    // ADC128S control word: channel address sits in bits [13:11].
    function automatic logic [15:0] a2d_cmd(input logic [2:0] ch);
        return {2'b00, ch, 11'h000};
    endfunction

endpackage

// File: rtl/SPI_mstr16.sv
// 16-bit SPI master: SCLK idles high, MOSI launched on SCLK fall, MISO sampled on SCLK rise.
module SPI_mstr16 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wrt,
    input  logic [15:0] cmd,
    output logic        done,
    output logic [15:0] rd_data,
    output logic        SS_n,
    output logic        SCLK,
    output logic        MOSI,
    input  logic        MISO
);

    typedef enum logic [1:0] {S_IDLE, S_XFER, S_BACK} spi_state_t;

    spi_state_t  state;
    logic [15:0] shft_reg;
    logic [3:0]  sclk_div;
    logic [3:0]  bit_cnt;
    logic        first_fall;
    logic        miso_smpl;

    assign MOSI    = shft_reg[15];
    assign rd_data = shft_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            shft_reg   <= 16'h0000;
            sclk_div   <= 4'd0;
            bit_cnt    <= 4'd0;
            first_fall <= 1'b1;
            miso_smpl  <= 1'b0;
            SS_n       <= 1'b1;
            SCLK       <= 1'b1;
            done       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (wrt) begin
                        shft_reg   <= cmd;
                        sclk_div   <= 4'd8;
                        bit_cnt    <= 4'd0;
                        first_fall <= 1'b1;
                        SS_n       <= 1'b0;
                        done       <= 1'b0;
                        state      <= S_XFER;
                    end
                end
                S_XFER: begin
                    sclk_div <= sclk_div + 4'd1;
                    if (sclk_div == 4'd7) begin
                        SCLK      <= 1'b1;
                        miso_smpl <= MISO;
                    end else if (sclk_div == 4'd15) begin
                        first_fall <= 1'b0;
                        // The leading fall only opens the frame; later falls shift a sampled bit in.
                        if (first_fall) begin
                            SCLK <= 1'b0;
                        end else begin
                            shft_reg <= {shft_reg[14:0], miso_smpl};
                            bit_cnt  <= bit_cnt + 4'd1;
                            if (bit_cnt == 4'd15)
                                state <= S_BACK;
                            else
                                SCLK <= 1'b0;
                        end
                    end
                end
                S_BACK: begin
                    SS_n  <= 1'b1;
                    done  <= 1'b1;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/a2d_chnl_seq.sv
// Round-robin sequencer reading three ADC128S channels through an embedded SPI_mstr16.
import a2d_pkg::*;

module a2d_chnl_seq #(
    parameter logic [2:0] CH0 = 3'd0,
    parameter logic [2:0] CH1 = 3'd4,
    parameter logic [2:0] CH2 = 3'd5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        strt_cnv,
    output logic [11:0] res0,
    output logic [11:0] res1,
    output logic [11:0] res2,
    output logic        cnv_cmplt,
    output logic        busy,
    output logic        SS_n,
    output logic        SCLK,
    output logic        MOSI,
    input  logic        MISO
);

    seq_state_t  state;
    logic [1:0]  idx;
    logic        wrt;
    logic [15:0] cmd;
    logic        done;
    logic        done_ff;
    logic [15:0] rd_data;
    logic        done_rise;
    logic        unused_rd_hi;

    assign done_rise    = done & ~done_ff;
    assign unused_rd_hi = ^rd_data[15:12];

    function automatic logic [2:0] ch_sel(input logic [1:0] i);
        case (i)
            2'd0:    return CH0;
            2'd1:    return CH1;
            default: return CH2;
        endcase
    endfunction

    SPI_mstr16 u_spi (
        .clk     (clk),
        .rst_n   (rst_n),
        .wrt     (wrt),
        .cmd     (cmd),
        .done    (done),
        .rd_data (rd_data),
        .SS_n    (SS_n),
        .SCLK    (SCLK),
        .MOSI    (MOSI),
        .MISO    (MISO)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= 2'd0;
            wrt       <= 1'b0;
            cmd       <= 16'h0000;
            done_ff   <= 1'b0;
            res0      <= 12'h000;
            res1      <= 12'h000;
            res2      <= 12'h000;
            cnv_cmplt <= 1'b0;
            busy      <= 1'b0;
        end else begin
            done_ff   <= done;
            wrt       <= 1'b0;
            cnv_cmplt <= 1'b0;
            case (state)
                // CMPLT returns to idle on this edge, so it samples strt_cnv like IDLE does.
                IDLE, CMPLT: begin
                    if (strt_cnv) begin
                        idx   <= 2'd0;
                        cmd   <= a2d_cmd(CH0);
                        wrt   <= 1'b1;
                        busy  <= 1'b1;
                        state <= SEND1;
                    end else begin
                        state <= IDLE;
                    end
                end
                SEND1: state <= WAIT1;
                WAIT1: if (done_rise) state <= GAP;
                GAP: begin
                    wrt   <= 1'b1;
                    state <= SEND2;
                end
                SEND2: state <= WAIT2;
                WAIT2: begin
                    if (done_rise) begin
                        case (idx)
                            2'd0:    res0 <= rd_data[11:0];
                            2'd1:    res1 <= rd_data[11:0];
                            default: res2 <= rd_data[11:0];
                        endcase
                        state <= NEXT;
                    end
                end
                NEXT: begin
                    if (idx == 2'(NUM_CH - 1)) begin
                        cnv_cmplt <= 1'b1;
                        busy      <= 1'b0;
                        state     <= CMPLT;
                    end else begin
                        idx   <= idx + 2'd1;
                        cmd   <= a2d_cmd(ch_sel(idx + 2'd1));
                        wrt   <= 1'b1;
                        state <= SEND1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_a2d_chnl_seq.sv
// Bench for a2d_chnl_seq: ADC128S-style slave on the SPI pins plus round-level result model.
module tb_a2d_chnl_seq;

    logic        clk;
    logic        rst_n;
    logic        strt_cnv;
    logic [11:0] res0, res1, res2;
    logic        cnv_cmplt;
    logic        busy;
    logic        SS_n, SCLK, MOSI, MISO;

    int vecs = 0;
    int errs = 0;
    int rnd = 0;
    int cmplt_cnt = 0;
    int ss_falls = 0;

    a2d_chnl_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .strt_cnv  (strt_cnv),
        .res0      (res0),
        .res1      (res1),
        .res2      (res2),
        .cnv_cmplt (cnv_cmplt),
        .busy      (busy),
        .SS_n      (SS_n),
        .SCLK      (SCLK),
        .MOSI      (MOSI),
        .MISO      (MISO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ADC slave: each frame returns the reading for the channel addressed in the previous frame;
    // the reading base drops by 0x10 every second frame since reset.
    logic [15:0] adc_tx, adc_rx;
    logic [2:0]  adc_prev;
    logic        adc_ss_q, adc_sclk_q;
    int          adc_k, adc_rises, adc_v;

    always @(negedge clk) begin
        if (!rst_n) begin
            adc_k = 0; adc_prev = 3'd0; adc_ss_q = 1'b1; adc_sclk_q = 1'b1;
            adc_rises = 0; adc_tx = 16'h0; adc_rx = 16'h0; MISO = 1'b0;
        end else begin
            if (adc_ss_q && !SS_n) begin
                adc_v = 'hC00 - 16 * (adc_k / 2) + int'(adc_prev);
                adc_tx = {4'h0, adc_v[11:0]};
                MISO = adc_tx[15];
                adc_rises = 0;
                ss_falls++;
            end
            if (!adc_ss_q && SS_n) begin
                adc_prev = adc_rx[13:11];
                adc_k++;
            end
            if (!SS_n && !adc_sclk_q && SCLK) begin
                adc_rx = {adc_rx[14:0], MOSI};
                adc_rises++;
            end
            if (!SS_n && adc_sclk_q && !SCLK && adc_rises > 0) begin
                adc_tx = {adc_tx[14:0], 1'b0};
                MISO = adc_tx[15];
            end
            adc_ss_q = SS_n;
            adc_sclk_q = SCLK;
        end
    end

    always @(negedge clk) if (cnv_cmplt) cmplt_cnt++;

    // Handshake watch: one-clock wrt, cmd frozen for the whole SS_n-low frame.
    logic        wrt_q, mon_ss_q, cmd_chg;
    logic [15:0] cmd_at_fall;

    always @(negedge clk) begin
        if (!rst_n) begin
            wrt_q = 1'b0; mon_ss_q = 1'b1; cmd_chg = 1'b0;
        end else begin
            if (wrt_q) begin
                vecs++;
                assert (dut.wrt === 1'b0) else begin
                    errs++; $error("FAIL wrt_width obs=%b exp=0", dut.wrt);
                end
            end
            wrt_q = dut.wrt;
            if (mon_ss_q && !SS_n) begin
                cmd_at_fall = dut.cmd;
                cmd_chg = 1'b0;
            end else if (!SS_n && dut.cmd !== cmd_at_fall) begin
                cmd_chg = 1'b1;
            end
            if (!mon_ss_q && SS_n) begin
                vecs++;
                assert (cmd_chg === 1'b0) else begin
                    errs++; $error("FAIL cmd_stable obs=changed exp=stable cmd=%h", cmd_at_fall);
                end
            end
            mon_ss_q = SS_n;
        end
    end

    // Result for channel slot i of round r since reset (channels 0, 4, 5).
    function automatic logic [11:0] exp_res(input int r, input int i);
        int ch, v;
        ch = (i == 0) ? 0 : (i == 1) ? 4 : 5;
        v = 'hC00 - 16 * (3 * r + i) + ch;
        return v[11:0];
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++; $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_cmplt(input string tag);
        int n;
        n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (cnv_cmplt !== 1'b1 && n < 2000);
        chk({tag, "_cmplt_timeout"}, 16'(cnv_cmplt), 16'h1);
    endtask

    task automatic wait_ss(input string tag, input int target);
        int n;
        n = 0;
        while (ss_falls < target && n < 2000) begin
            @(negedge clk); n++;
        end
        chk({tag, "_ss_timeout"}, 16'(ss_falls >= target), 16'h1);
    endtask

    task automatic check_round(input string tag);
        chk({tag, "_res0"}, 16'(res0), 16'(exp_res(rnd, 0)));
        chk({tag, "_res1"}, 16'(res1), 16'(exp_res(rnd, 1)));
        chk({tag, "_res2"}, 16'(res2), 16'(exp_res(rnd, 2)));
        rnd++;
    endtask

    task automatic start_pulse(input string tag, input int w);
        @(negedge clk); strt_cnv = 1'b1;
        @(posedge clk); #1;
        chk({tag, "_busy"}, 16'(busy), 16'h1);
        chk({tag, "_wrt"}, 16'(dut.wrt), 16'h1);
        repeat (w - 1) @(posedge clk);
        @(negedge clk); strt_cnv = 1'b0;
    endtask

    task automatic full_round(input string tag);
        int c0, s0;
        repeat ($urandom_range(1, 20)) @(posedge clk);
        c0 = cmplt_cnt; s0 = ss_falls;
        start_pulse(tag, $urandom_range(1, 4));
        wait_cmplt(tag);
        check_round(tag);
        @(posedge clk); #1;
        chk({tag, "_cmplt_width"}, 16'(cnv_cmplt), 16'h0);
        chk({tag, "_cmplt_cnt"}, 16'(cmplt_cnt - c0), 16'h1);
        chk({tag, "_ss_falls"}, 16'(ss_falls - s0), 16'h6);
    endtask

    initial begin
        int c0, s0;
        rst_n = 1'b0; strt_cnv = 1'b0;
        repeat (3) @(posedge clk); #1;
        chk("rst_res0", 16'(res0), 16'h0);
        chk("rst_res1", 16'(res1), 16'h0);
        chk("rst_res2", 16'(res2), 16'h0);
        chk("rst_busy", 16'(busy), 16'h0);
        chk("rst_cmplt", 16'(cnv_cmplt), 16'h0);
        chk("rst_wrt", 16'(dut.wrt), 16'h0);
        chk("rst_cmd", dut.cmd, 16'h0);
        chk("rst_ss_n", 16'(SS_n), 16'h1);
        @(negedge clk); rst_n = 1'b1;

        full_round("round1");
        full_round("round2");

        // Extra strt_cnv pulse while the CH1 setup frame is in flight.
        c0 = cmplt_cnt; s0 = ss_falls;
        start_pulse("mid_start", 1);
        wait_ss("mid", s0 + 3);
        repeat ($urandom_range(5, 200)) @(posedge clk);
        @(negedge clk); strt_cnv = 1'b1;
        @(negedge clk); strt_cnv = 1'b0;
        wait_cmplt("mid");
        check_round("mid");
        repeat (30) @(posedge clk); #1;
        chk("mid_busy_after", 16'(busy), 16'h0);
        chk("mid_cmplt_cnt", 16'(cmplt_cnt - c0), 16'h1);
        chk("mid_ss_falls", 16'(ss_falls - s0), 16'h6);

        // Reset during the CH0 capture frame.
        s0 = ss_falls;
        start_pulse("rst_mid_start", 1);
        wait_ss("rst_mid", s0 + 2);
        repeat ($urandom_range(10, 200)) @(posedge clk);
        @(negedge clk); rst_n = 1'b0; #1;
        chk("rst_mid_busy", 16'(busy), 16'h0);
        chk("rst_mid_wrt", 16'(dut.wrt), 16'h0);
        chk("rst_mid_res0", 16'(res0), 16'h0);
        chk("rst_mid_res1", 16'(res1), 16'h0);
        chk("rst_mid_res2", 16'(res2), 16'h0);
        chk("rst_mid_ss_n", 16'(SS_n), 16'h1);
        rnd = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        full_round("post_rst");

        // strt_cnv held high: back-to-back rounds.
        repeat ($urandom_range(1, 10)) @(posedge clk);
        c0 = cmplt_cnt;
        @(negedge clk); strt_cnv = 1'b1;
        @(posedge clk); #1;
        chk("held_busy", 16'(busy), 16'h1);
        wait_cmplt("held1");
        check_round("held1");
        @(posedge clk); #1;
        chk("held_rewrt", 16'(dut.wrt), 16'h1);
        chk("held_rebusy", 16'(busy), 16'h1);
        chk("held_cmplt_width", 16'(cnv_cmplt), 16'h0);
        wait_cmplt("held2");
        strt_cnv = 1'b0;
        check_round("held2");
        repeat (5) @(posedge clk); #1;
        chk("held_end_busy", 16'(busy), 16'h0);
        chk("held_end_wrt", 16'(dut.wrt), 16'h0);
        chk("held_cmplt_cnt", 16'(cmplt_cnt - c0), 16'h2);

        full_round("tail1");
        full_round("tail2");

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/a2d_chnl_seq.md
# a2d_chnl_seq

Round-robin A/D channel sequencer. It sits directly upstream of `SPI_mstr16` and drives that block's `wrt`/`cmd` handshake to read three ADC128S channels, then consumes `rd_data` into per-channel result registers. One `strt_cnv` pulse starts one conversion round; `cnv_cmplt` pulses when all three results are fresh. `SPI_mstr16` is instantiated inside this block, and only the SPI pins are exported.

## Interface
Parameters:
- `CH0`, default `3'd0`: first channel in the round.
- `CH1`, default `3'd4`: second channel.
- `CH2`, default `3'd5`: third channel.

Ports:
- `clk` in, 1: system clock; the block has one clock.
- `rst_n` in, 1: asynchronous active-low reset.
- `strt_cnv` in, 1: start a round; sampled only in IDLE.
- `res0`, `res1`, `res2` out, 12 each: latest results for `CH0`, `CH1`, `CH2`.
- `cnv_cmplt` out, 1: one-clock pulse at the end of a round.
- `busy` out, 1: high from round start until `cnv_cmplt`.
- `SS_n`, `SCLK`, `MOSI` out, 1 each: SPI pins, passed through from `SPI_mstr16`.
- `MISO` in, 1: SPI input, passed through to `SPI_mstr16`.

## Operation
- **Command word:** `{2'b00, ch[2:0], 11'h000}`.
- **Why two transactions per channel:** the ADC returns the channel requested in the previous transaction. Each channel therefore takes two transactions with the identical `cmd`:
  - first transaction: sets up the channel; its `rd_data` is discarded;
  - second transaction: its `rd_data[11:0]` is captured into `res[idx]`.
- **State machine:**
  - IDLE: `strt_cnv` high → SEND1, with `idx`=0.
  - SEND1: `wrt`=1 for one clock, `cmd` loaded → WAIT1.
  - WAIT1: on a `done` rise → GAP.
  - GAP: one clock → SEND2.
  - SEND2: `wrt`=1 for one clock, same `cmd` → WAIT2.
  - WAIT2: on a `done` rise, capture into `res[idx]` → NEXT.
  - NEXT: if `idx`=2 → CMPLT; else `idx`+1 → SEND1.
  - CMPLT: `cnv_cmplt`=1 for one clock → IDLE.
- **`done` handling:** `done` is treated as a level. Only its rising edge (`done & ~done_ff`) advances the FSM, so a `done` still held from the previous transaction never counts twice.
- **`cmd`:** registered, and stable from the SEND state through the end of that transaction.
- **`rd_data[15:12]`:** ignored.
- **Boundary conditions:**
  - `strt_cnv` while `busy`: ignored, not queued.
  - `strt_cnv` held high: a new round starts on the first IDLE clock after CMPLT; rounds repeat back to back.
  - Partial rounds: results not captured by an incomplete round keep their previous values.
  - Reset mid-round: returns to IDLE immediately. `wrt` drops and `SPI_mstr16` resets with the same `rst_n`; no capture occurs.
- **Reset values:**
  - `res0`, `res1`, `res2` = `12'h000`;
  - `cnv_cmplt` = 0;
  - `busy` = 0;
  - `wrt` = 0, `cmd` = `16'h0000`;
  - `idx` = 0, FSM in IDLE.

## Timing
- `strt_cnv` sampled high at edge N: `busy` and `wrt` are both high in cycle N+1.
- Each `wrt` pulse lasts exactly one clock.
- Next `wrt` after a `done` rise is detected at edge M:
  - WAIT1 → GAP → SEND2: `wrt` is high in cycle M+2;
  - WAIT2 → NEXT → SEND1: `wrt` is high in cycle M+2.
- Result capture: `res[idx]` updates at the edge where the `done` rise is detected.
- Round end: after the final capture at edge M, `cnv_cmplt` is high in cycle M+2 and `busy` falls with it.
- Round latency: 6 × T_spi + 12 clocks, where T_spi is the `SPI_mstr16` `wrt`-to-`done` latency.
- All outputs are registered; there are no combinational input-to-output paths.

## Structure
- Package `a2d_pkg`:
  - state enum `seq_state_t` (IDLE, SEND1, WAIT1, GAP, SEND2, WAIT2, NEXT, CMPLT);
  - `NUM_CH` = 3;
  - function `a2d_cmd(ch)` returning the 16-bit command word.
- Sub-module: one instance of `SPI_mstr16`, connected on `wrt`, `cmd`, `done`, `rd_data` and the four SPI pins.
- Bench: pairs the DUT with the `ADC128S` model on the SPI pins.

## Test plan
- **Reset, then first round:** reset, one `strt_cnv` pulse → `cnv_cmplt` once; `res0`=0xC00, `res1`=0xBF4, `res2`=0xBE5.
- **Second round:** another `strt_cnv` pulse → `res0`=0xBD0, `res1`=0xBC4, `res2`=0xBB5; exactly 6 `SS_n` falling edges per round.
- **Pulse mid-round:** `strt_cnv` pulsed during the WAIT1 of the CH1 transaction → ignored; one `cnv_cmplt` only, and the next round's results follow the ADC model's sequence unchanged.
- **Reset mid-round:** reset asserted during WAIT2 of CH0 → `busy`=0, `wrt`=0, all `res` registers=0 on the same edge. A fresh round afterwards restarts the model and gives 0xC00/0xBF4/0xBE5.
- **`strt_cnv` held high:** 2 complete rounds, `cnv_cmplt` pulses one clock wide, and each next `wrt` is high one clock after the `cnv_cmplt` cycle.
- **Handshake checks:** every `wrt` pulse is one clock; `cmd` is stable while `SS_n`=0. A 2000-clock timeout on each `cnv_cmplt` is flagged as an error.
